// File: rtl/signal_indicator_pkg.sv
// Shared types and sizing helpers for the multi-channel activity indicator.
package signal_indicator_pkg;

  typedef enum logic [1:0] {SI_IDLE, SI_QUAL, SI_ACTIVE} si_state_t;

  function automatic int si_cnt_w(input int c_max);
    return $clog2(c_max + 1);
  endfunction

endpackage

// File: rtl/signal_indicator_ch.sv
// One channel: synchroniser, edge detect, qualify/timeout FSM, sticky loss flag.
// Edge reaches the FSM SYNC_STAGES+1 clocks after an input change; all outputs registered.
module signal_indicator_ch
  import signal_indicator_pkg::*;
#(
  parameter int C_MAX       = 10_000,
  parameter int MIN_EDGES   = 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic in,
  input  logic en,
  input  logic clr_lost,
  output logic active,
  output logic gained,
  output logic lost,
  output logic lost_sticky
);

  localparam int TW = si_cnt_w(C_MAX);
  localparam int EW = si_cnt_w(MIN_EDGES);
  localparam logic [TW-1:0] TCNT_MAX  = TW'(C_MAX);
  localparam logic [TW-1:0] TCNT_ONE  = TW'(1);
  localparam logic [EW-1:0] ECNT_ONE  = EW'(1);
  localparam logic [EW-1:0] ECNT_SAT  = EW'(MIN_EDGES);
  localparam logic [EW:0]   ECNT_QUAL = (EW+1)'(MIN_EDGES);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_hist;
  si_state_t              r_state;
  logic [TW-1:0]          r_tcnt;
  logic [EW-1:0]          r_ecnt;
  logic                   r_active;
  logic                   r_gained;
  logic                   r_lost;
  logic                   r_lost_sticky;

  logic          w_edge;
  logic          w_tcnt_last;
  logic          w_timeout;
  logic [EW:0]   w_ecnt_inc;
  logic [EW-1:0] w_ecnt_sat;

  // The synchroniser and history flop ignore en so re-enabling never sees a stale edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync <= '0;
      r_hist <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], in};
      r_hist <= r_sync[SYNC_STAGES-1];
    end
  end

  assign w_edge      = r_sync[SYNC_STAGES-1] ^ r_hist;
  assign w_tcnt_last = (r_tcnt == TCNT_ONE);
  assign w_timeout   = en && (r_state == SI_ACTIVE) && !w_edge && w_tcnt_last;
  assign w_ecnt_inc  = {1'b0, r_ecnt} + 1'b1;
  assign w_ecnt_sat  = (r_ecnt == ECNT_SAT) ? r_ecnt : w_ecnt_inc[EW-1:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= SI_IDLE;
      r_tcnt   <= '0;
      r_ecnt   <= '0;
      r_active <= 1'b0;
      r_gained <= 1'b0;
      r_lost   <= 1'b0;
    end else begin
      r_gained <= 1'b0;
      r_lost   <= 1'b0;
      if (!en) begin
        r_state  <= SI_IDLE;
        r_tcnt   <= '0;
        r_ecnt   <= '0;
        r_active <= 1'b0;
      end else begin
        case (r_state)
          SI_IDLE: begin
            if (w_edge) begin
              r_tcnt <= TCNT_MAX;
              r_ecnt <= ECNT_ONE;
              if (MIN_EDGES == 1) begin
                r_state  <= SI_ACTIVE;
                r_active <= 1'b1;
                r_gained <= 1'b1;
              end else begin
                r_state <= SI_QUAL;
              end
            end
          end
          SI_QUAL: begin
            if (w_edge) begin
              r_tcnt <= TCNT_MAX;
              r_ecnt <= w_ecnt_sat;
              if (w_ecnt_inc == ECNT_QUAL) begin
                r_state  <= SI_ACTIVE;
                r_active <= 1'b1;
                r_gained <= 1'b1;
              end
            end else begin
              r_tcnt <= r_tcnt - TCNT_ONE;
              if (w_tcnt_last) begin
                r_state <= SI_IDLE;
                r_ecnt  <= '0;
              end
            end
          end
          SI_ACTIVE: begin
            if (w_edge) begin
              r_tcnt <= TCNT_MAX;
            end else begin
              r_tcnt <= r_tcnt - TCNT_ONE;
              if (w_tcnt_last) begin
                r_state  <= SI_IDLE;
                r_ecnt   <= '0;
                r_active <= 1'b0;
                r_lost   <= 1'b1;
              end
            end
          end
          default: begin
            r_state  <= SI_IDLE;
            r_tcnt   <= '0;
            r_ecnt   <= '0;
            r_active <= 1'b0;
          end
        endcase
      end
    end
  end

  // Set is honoured both on the timeout edge and while lost is visible, so a clear
  // coinciding with either never swallows a fresh loss.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_lost_sticky <= 1'b0;
    end else if (w_timeout || r_lost) begin
      r_lost_sticky <= 1'b1;
    end else if (clr_lost) begin
      r_lost_sticky <= 1'b0;
    end
  end

  assign active      = r_active;
  assign gained      = r_gained;
  assign lost        = r_lost;
  assign lost_sticky = r_lost_sticky;

endmodule

// File: rtl/signal_indicator_mc.sv
// N_CH independent activity indicators plus an any-active summary.
// any_active is a pure OR of the registered per-channel active bits.
module signal_indicator_mc
  import signal_indicator_pkg::*;
#(
  parameter int N_CH        = 4,
  parameter int C_MAX       = 10_000,
  parameter int MIN_EDGES   = 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N_CH-1:0] in,
  input  logic [N_CH-1:0] en,
  input  logic [N_CH-1:0] clr_lost,
  output logic [N_CH-1:0] active,
  output logic [N_CH-1:0] gained,
  output logic [N_CH-1:0] lost,
  output logic [N_CH-1:0] lost_sticky,
  output logic            any_active
);

  if (N_CH < 1 || C_MAX < 1 || MIN_EDGES < 1 || SYNC_STAGES < 2) begin : g_param_check
    $error("signal_indicator_mc: N_CH, C_MAX, MIN_EDGES must be >=1 and SYNC_STAGES >=2");
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    signal_indicator_ch #(
      .C_MAX      (C_MAX),
      .MIN_EDGES  (MIN_EDGES),
      .SYNC_STAGES(SYNC_STAGES)
    ) u_ch (
      .clk        (clk),
      .reset      (reset),
      .in         (in[g]),
      .en         (en[g]),
      .clr_lost   (clr_lost[g]),
      .active     (active[g]),
      .gained     (gained[g]),
      .lost       (lost[g]),
      .lost_sticky(lost_sticky[g])
    );
  end

  assign any_active = |active;

endmodule

// File: tb/tb_signal_indicator_mc.sv
// Directed bench for signal_indicator_mc with N_CH=4, C_MAX=16, MIN_EDGES=3, SYNC_STAGES=2.
module tb_signal_indicator_mc;

  localparam int N_CH        = 4;
  localparam int C_MAX       = 16;
  localparam int MIN_EDGES   = 3;
  localparam int SYNC_STAGES = 2;

  logic            clk = 1'b0;
  logic            reset;
  logic [N_CH-1:0] in;
  logic [N_CH-1:0] en;
  logic [N_CH-1:0] clr_lost;
  logic [N_CH-1:0] active;
  logic [N_CH-1:0] gained;
  logic [N_CH-1:0] lost;
  logic [N_CH-1:0] lost_sticky;
  logic            any_active;

  int              n_checks = 0;
  int              n_errors = 0;
  logic [N_CH-1:0] seen;

  always #5 clk = ~clk;

  signal_indicator_mc #(
    .N_CH       (N_CH),
    .C_MAX      (C_MAX),
    .MIN_EDGES  (MIN_EDGES),
    .SYNC_STAGES(SYNC_STAGES)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .in         (in),
    .en         (en),
    .clr_lost   (clr_lost),
    .active     (active),
    .gained     (gained),
    .lost       (lost),
    .lost_sticky(lost_sticky),
    .any_active (any_active)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance n rising edges, landing 1 time unit after the last one.
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Accumulate any activity/pulse seen on the masked channels over n cycles.
  task automatic watch(input int n, input logic [N_CH-1:0] mask);
    for (int i = 0; i < n; i++) begin
      step(1);
      seen = seen | ((active | gained | lost) & mask);
    end
  endtask

  initial begin
    reset    = 1'b1;
    in       = '0;
    en       = '1;
    clr_lost = '0;
    #2;
    check("rst_active", 32'(active), 32'h0);
    check("rst_pulses", 32'({gained, lost}), 32'h0);
    check("rst_sticky", 32'(lost_sticky), 32'h0);
    check("rst_any", 32'(any_active), 32'h0);
    step(3);
    reset = 1'b0;
    step(2);

    // Scenario 1: ch0 qualifies on its third edge.
    in[0] = ~in[0]; step(4);
    in[0] = ~in[0]; step(4);
    in[0] = ~in[0]; step(2);
    check("s1_not_yet", 32'(active), 32'h0);
    step(1);
    check("s1_active", 32'(active), 32'h1);
    check("s1_gained", 32'(gained), 32'h1);
    check("s1_any", 32'(any_active), 32'h1);
    step(1);
    check("s1_gained_once", 32'(gained), 32'h0);
    in[0] = ~in[0]; step(4);
    check("s1_hold", 32'(active), 32'h1);
    in[0] = ~in[0];

    // Scenario 2: last edge sampled 3 clocks later; loss 16 clocks after that.
    step(18);
    check("s2_still_active", 32'(active), 32'h1);
    check("s2_no_lost_yet", 32'(lost), 32'h0);
    step(1);
    check("s2_active_fall", 32'(active), 32'h0);
    check("s2_lost", 32'(lost), 32'h1);
    check("s2_sticky", 32'(lost_sticky), 32'h1);
    check("s2_any_fall", 32'(any_active), 32'h0);
    step(1);
    check("s2_lost_once", 32'(lost), 32'h0);
    check("s2_sticky_hold", 32'(lost_sticky), 32'h1);

    // Scenario 3: two edges too far apart never qualify ch1.
    seen = '0;
    in[1] = ~in[1];
    watch(20, 4'b0010);
    in[1] = ~in[1];
    watch(40, 4'b0010);
    check("s3_never_active", 32'(seen), 32'h0);
    clr_lost = 4'b0010;
    step(1);
    clr_lost = '0;
    check("s3_clr_on_zero", 32'(lost_sticky), 32'h1);

    // Scenario 5: clear asserted while a fresh loss arrives on ch0.
    in[0] = ~in[0]; step(4);
    in[0] = ~in[0]; step(4);
    in[0] = ~in[0]; step(3);
    check("s5_active", 32'(active), 32'h1);
    step(15);
    check("s5_pre_loss", 32'({active, lost_sticky}), 32'h11);
    clr_lost = 4'b0001;
    step(1);
    check("s5_lost", 32'(lost), 32'h1);
    check("s5_set_wins", 32'(lost_sticky), 32'h1);
    step(1);
    check("s5_set_wins_pulse", 32'(lost_sticky), 32'h1);
    step(1);
    check("s5_clr_alone", 32'(lost_sticky), 32'h0);
    clr_lost = '0;

    // Scenario 4: one-cycle disable on active ch2.
    in[2] = ~in[2]; step(4);
    in[2] = ~in[2]; step(4);
    in[2] = ~in[2]; step(3);
    check("s4_active", 32'(active), 32'h4);
    check("s4_gained", 32'(gained), 32'h4);
    step(1);
    en[2] = 1'b0;
    step(1);
    check("s4_disabled", 32'(active), 32'h0);
    check("s4_no_pulse", 32'({gained, lost}), 32'h0);
    en[2] = 1'b1;
    seen = '0;
    watch(30, 4'b0100);
    check("s4_reenable_quiet", 32'(seen), 32'h0);
    check("s4_sticky_untouched", 32'(lost_sticky), 32'h0);

    // Scenario 6: async reset mid-cycle with all channels active.
    in = ~in; step(4);
    in = ~in; step(4);
    in = ~in; step(3);
    check("s6_all_active", 32'(active), 32'hF);
    check("s6_any", 32'(any_active), 32'h1);
    #2;
    reset = 1'b1;
    #1;
    check("s6_rst_active", 32'(active), 32'h0);
    check("s6_rst_any", 32'(any_active), 32'h0);
    check("s6_rst_pulses", 32'({gained, lost, lost_sticky}), 32'h0);
    step(2);
    reset = 1'b0;
    seen = '0;
    watch(40, 4'hF);
    check("s6_post_quiet", 32'(seen), 32'h0);
    check("s6_post_sticky", 32'(lost_sticky), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
